adder_exerciser: RTL
====================

# adder_exerciser

Self-checking stimulus/response block for the registered 8-bit adder top. It sits at the far end of that adder's operand/result interface. It drives operand pairs A/B each cycle and tracks the expected sums through a matching pipeline. It compares the returned S/Cout, then reports pass/fail and an error count.

## Interface
- NUM_VECTORS, 256: operand pairs issued per run (1..65535)
- LATENCY, 2: clk edges from A/B change to matching S/Cout change at the adder outputs (≥1)
- SEED, 8'h01: LFSR start value for B; 8'h00 is replaced by 8'h01
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- A  out  8  operand A to adder, registered
- B  out  8  operand B to adder, registered
- S  in  8  adder sum
- Cout  in  1  adder carry-out
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE, held until next start
- pass  out  1  high in DONE when err_count == 0
- err_count  out  16  mismatches this run, saturates at 16'hFFFF
- fail_a, fail_b  out  8 each  operands of first mismatch; 0 if none

## Operation
- States: IDLE → RUN → DRAIN → DONE → (start) RUN.
- IDLE: start=1 → RUN. Issue counter, err_count, fail_a/fail_b, and expected pipe are cleared. LFSR is loaded with SEED. A/B drive vector 0.
- RUN: one vector is issued per cycle. Vector k is A = k[7:0], B = LFSR state k.
- LFSR advance: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- After vector NUM_VECTORS-1 is issued → DRAIN. A/B hold the last vector.
- DRAIN: lasts LATENCY cycles, then → DONE.
- DONE: start=1 → RUN with a full clear, as from IDLE.
- start is ignored in RUN and DRAIN.
- Expected pipe: LATENCY+1 stages of {valid, A, B, exp[8:0]}, with exp = A + B as a 9-bit zero-extended sum.
- A stage enters the pipe valid for every issued vector. Bubbles enter during DRAIN and idle states.
- Compare at the pipe tail when valid: {Cout,S} ≠ exp → err_count += 1 (saturating). The first mismatch captures fail_a/fail_b.
- pass = done & (err_count == 0).

## Timing
- Reset: state IDLE; A, B, err_count, fail_a, fail_b = 0; busy, done, pass = 0; pipe valids = 0.
- Reset mid-run aborts immediately with the same values. No partial result survives.
- start sampled at edge e0: busy=1 and A/B = vector 0 after e0. Vector k is driven after edge e0+k.
- Vector k is compared at edge e0+k+LATENCY+1.
- Last compare is at e0+NUM_VECTORS+LATENCY. busy falls and done/pass rise after the same edge, and the final err_count is visible then.
- Run length: NUM_VECTORS+LATENCY+1 cycles from start to done.
- Error and first-fail updates take effect on the compare edge.
- A simultaneous first mismatch and saturation both apply.

## Configuration
- ADDER_EXERCISER_EXHAUSTIVE_EN defined: NUM_VECTORS is ignored. The run issues 65536 vectors with A = k[7:0] and B = k[15:8], and the LFSR is not instantiated.
- Undefined: NUM_VECTORS counter/LFSR mode as described above.

## Test plan
- Reset: rst_n=0 mid-RUN → all outputs 0 and state IDLE within the same cycle. A later start gives a complete fresh run.
- Clean run, NUM_VECTORS=4, SEED=8'h01, ideal 2-cycle adder model:
  - Vectors (0,01), (1,02), (2,04), (3,08).
  - done after edge e0+6; err_count=0; pass=1.
- S[0] stuck-at-0 model, same configuration:
  - Expected sums 1, 3, 6, 11 → err_count=3.
  - fail_a=00, fail_b=01; pass=0.
- Cout stuck-at-1 model, same configuration → err_count=4, fail_a=00, fail_b=01.
- start pulses during RUN and DRAIN are ignored, and done still follows at e0+6. A start in DONE clears err_count and reruns identical vectors.
- Exhaustive build with ideal model:
  - 65536 vectors; last vector A=FF, B=FF with exp 9'h1FE checked.
  - done after edge e0+65538; pass=1.

Source files
------------

// File: rtl/adder_exerciser.sv
// rtl/adder_exerciser.sv - stimulus/response checker for a registered 8-bit adder
// Optional build macro: ADDER_EXERCISER_EXHAUSTIVE_EN (all 65536 A/B pairs, no LFSR)
module adder_exerciser #(
    parameter int         NUM_VECTORS = 256,
    parameter int         LATENCY     = 2,
    parameter logic [7:0] SEED        = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  A,
    output logic [7:0]  B,
    input  logic [7:0]  S,
    input  logic        Cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [7:0]  fail_a,
    output logic [7:0]  fail_b
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Tail stage index LATENCY lines up with the adder output one edge later.
    localparam int          DEPTH      = LATENCY + 1;
    localparam logic [15:0] DRAIN_LAST = 16'(LATENCY - 1);

`ifdef ADDER_EXERCISER_EXHAUSTIVE_EN
    localparam logic [15:0] LAST_IDX = 16'hFFFF;
`else
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
`endif

    logic [1:0]  state;
    logic [15:0] idx;
    logic [15:0] drain_cnt;

    logic [7:0]  nxt_a;
    logic [7:0]  nxt_b;
    logic [7:0]  first_b;
    logic        issue_first;
    logic        issue_next;
    logic        push;
    logic [7:0]  push_a;
    logic [7:0]  push_b;

    logic        pipe_v [DEPTH];
    logic [7:0]  pipe_a [DEPTH];
    logic [7:0]  pipe_b [DEPTH];
    logic [8:0]  pipe_e [DEPTH];
    logic        mismatch;

`ifdef ADDER_EXERCISER_EXHAUSTIVE_EN
    // Vector k is simply the 16-bit index split into A (low) and B (high).
    always_comb begin
        {nxt_b, nxt_a} = idx + 16'd1;
        first_b        = 8'h00;
    end
`else
    logic [7:0] lfsr;
    logic [7:0] lfsr_next;

    // Vector k uses the index for A and the k-th LFSR state for B.
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        nxt_a     = idx[7:0] + 8'd1;
        nxt_b     = lfsr_next;
        first_b   = SEED_EFF;
    end
`endif

    // Decide whether a fresh vector enters the adder (and the expected pipe) this edge.
    always_comb begin
        issue_first = ((state == S_IDLE) || (state == S_DONE)) && start;
        issue_next  = (state == S_RUN) && (idx != LAST_IDX);
        push        = issue_first || issue_next;
        push_a      = issue_first ? 8'h00 : nxt_a;
        push_b      = issue_first ? first_b : nxt_b;
    end

    // Run sequencing and registered operand drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= 16'd0;
            drain_cnt <= 16'd0;
            A         <= 8'h00;
            B         <= 8'h00;
`ifndef ADDER_EXERCISER_EXHAUSTIVE_EN
            lfsr      <= SEED_EFF;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        idx   <= 16'd0;
                        A     <= push_a;
                        B     <= push_b;
`ifndef ADDER_EXERCISER_EXHAUSTIVE_EN
                        lfsr  <= SEED_EFF;
`endif
                    end
                end
                S_RUN: begin
                    if (idx == LAST_IDX) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 16'd0;
                    end else begin
                        idx  <= idx + 16'd1;
                        A    <= push_a;
                        B    <= push_b;
`ifndef ADDER_EXERCISER_EXHAUSTIVE_EN
                        lfsr <= lfsr_next;
`endif
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Expected-result pipe: shifts every cycle, bubbles whenever nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= 8'h00;
                pipe_b[i] <= 8'h00;
                pipe_e[i] <= 9'h000;
            end
        end else begin
            pipe_v[0] <= push;
            pipe_a[0] <= push_a;
            pipe_b[0] <= push_b;
            pipe_e[0] <= {1'b0, push_a} + {1'b0, push_b};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_v[i] <= issue_first ? 1'b0 : pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    assign mismatch = pipe_v[LATENCY] && ({Cout, S} != pipe_e[LATENCY]);

    // Error accounting: saturating count, operands of the first mismatch latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 16'h0000;
            fail_a    <= 8'h00;
            fail_b    <= 8'h00;
        end else if (issue_first) begin
            err_count <= 16'h0000;
            fail_a    <= 8'h00;
            fail_b    <= 8'h00;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (err_count == 16'h0000) begin
                fail_a <= pipe_a[LATENCY];
                fail_b <= pipe_b[LATENCY];
            end
        end
    end

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 16'h0000);

endmodule
